// File: rtl/cmsdk_mcu_rstseq_pkg.sv
// Shared types for the MCU reset sequencer.
// State encodings, counter widths and load helpers.
package cmsdk_mcu_rstseq_pkg;

    localparam int HOLD_W = 8;
    localparam int DLY_W  = 4;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_REL_H  = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    function automatic logic [HOLD_W-1:0] hold_load(input int cycles);
        return HOLD_W'(cycles - 1);
    endfunction

    function automatic logic [DLY_W-1:0] dly_load(input int cycles);
        return (cycles > 0) ? DLY_W'(cycles - 1) : '0;
    endfunction

endpackage

// File: rtl/cmsdk_mcu_rstseq_if.sv
// Request/control inputs and reset/clock-enable outputs
// of the reset sequencer, grouped as one bundle.
interface cmsdk_mcu_rstseq_if #(
    parameter int NUM_SRC = 4,
    parameter int DIV_W   = 4
);
    logic [NUM_SRC-1:0] RSTREQ;
    logic               DBGRESETREQ;
    logic               RSTBYPASS;
    logic [DIV_W-1:0]   PCLKDIV;
    logic               CAUSE_CLR;
    logic               HRESETn;
    logic               PRESETn;
    logic               DBGRESETn;
    logic               PCLKEN;
    logic [NUM_SRC:0]   RSTCAUSE;
    logic               RSTBUSY;

    modport master (
        output RSTREQ, DBGRESETREQ, RSTBYPASS, PCLKDIV, CAUSE_CLR,
        input  HRESETn, PRESETn, DBGRESETn, PCLKEN, RSTCAUSE, RSTBUSY
    );

    modport slave (
        input  RSTREQ, DBGRESETREQ, RSTBYPASS, PCLKDIV, CAUSE_CLR,
        output HRESETn, PRESETn, DBGRESETn, PCLKEN, RSTCAUSE, RSTBUSY
    );
endinterface

// File: rtl/cmsdk_rst_sync.sv
// Reset synchroniser: asserts asynchronously, releases
// after STAGES clock edges.
module cmsdk_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic rst_n_sync
);
    logic [STAGES-1:0] sync_q;

    // Shift ones in behind the asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end

    assign rst_n_sync = sync_q[STAGES-1];
endmodule

// File: rtl/cmsdk_mcu_rstseq.sv
// MCU reset sequencer: staged HRESETn/PRESETn release, debug
// reset domain, programmable PCLKEN and sticky reset cause.
module cmsdk_mcu_rstseq
    import cmsdk_mcu_rstseq_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int HOLD_CYCLES  = 16,
    parameter int PRESET_DELAY = 4,
    parameter int DIV_W        = 4
) (
    input  logic                FCLK,
    input  logic                PORESET,
    cmsdk_mcu_rstseq_if.slave   bus
);
    if (NUM_SRC < 1 || NUM_SRC > 8) begin : g_bad_src
        $error("NUM_SRC out of range 1..8");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES out of range 2..4");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("HOLD_CYCLES out of range 1..255");
    end
    if (PRESET_DELAY < 0 || PRESET_DELAY > 15) begin : g_bad_dly
        $error("PRESET_DELAY out of range 0..15");
    end

    localparam logic [HOLD_W-1:0] HOLD_LD = hold_load(HOLD_CYCLES);
    localparam logic [DLY_W-1:0]  DLY_LD  = dly_load(PRESET_DELAY);

    logic               sys_sync;
    logic               dbg_sync;
    logic               por_q;
    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic               any_req;
    logic               capture;
    logic               hrst_q, prst_q, busy_q;
    logic               dbg_q, dreq_q;
    logic               pclken_q;
    logic [DIV_W-1:0]   div_q;
    logic [NUM_SRC:0]   cause_q;
    logic [NUM_SRC-1:0] cause_keep;

    cmsdk_rst_sync #(.STAGES(SYNC_STAGES)) u_sys_sync (
        .clk        (FCLK),
        .rst        (PORESET),
        .rst_n_sync (sys_sync)
    );

    cmsdk_rst_sync #(.STAGES(SYNC_STAGES)) u_dbg_sync (
        .clk        (FCLK),
        .rst        (PORESET),
        .rst_n_sync (dbg_sync)
    );

    assign any_req = |bus.RSTREQ;

    // Sequencer state, counters and the retimed POR release.
    always_ff @(posedge FCLK or posedge PORESET) begin
        if (PORESET) begin
            state_q <= ST_ASSERT;
            hold_q  <= HOLD_LD;
            dly_q   <= '0;
            por_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            dly_q   <= dly_d;
            por_q   <= sys_sync;
        end
    end

    // Next-state: hold after last request, then staged release.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        dly_d   = dly_q;
        capture = 1'b0;
        unique case (state_q)
            ST_ASSERT: begin
                if (!por_q || any_req) begin
                    hold_d = HOLD_LD;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (PRESET_DELAY == 0) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_REL_H;
                    dly_d   = DLY_LD;
                end
            end
            ST_REL_H: begin
                if (any_req) begin
                    state_d = ST_ASSERT;
                    hold_d  = HOLD_LD;
                    capture = 1'b1;
                end else if (dly_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (any_req) begin
                    state_d = ST_ASSERT;
                    hold_d  = HOLD_LD;
                    capture = 1'b1;
                end
            end
            default: state_d = ST_ASSERT;
        endcase
    end

    assign cause_keep = bus.CAUSE_CLR ? '0 : cause_q[NUM_SRC-1:0];

    // Registered resets, busy flag and sticky cause.
    always_ff @(posedge FCLK or posedge PORESET) begin
        if (PORESET) begin
            hrst_q  <= 1'b0;
            prst_q  <= 1'b0;
            busy_q  <= 1'b1;
            cause_q <= {1'b1, {NUM_SRC{1'b0}}};
        end else begin
            hrst_q <= (state_d != ST_ASSERT);
            prst_q <= (state_d == ST_RUN);
            busy_q <= (state_d != ST_RUN);
            if (capture)
                cause_q <= {1'b0, cause_keep | bus.RSTREQ};
            else if (bus.CAUSE_CLR)
                cause_q <= '0;
        end
    end

    // Debug reset: low while requested and one cycle beyond.
    always_ff @(posedge FCLK or posedge PORESET) begin
        if (PORESET) begin
            dbg_q  <= 1'b0;
            dreq_q <= 1'b0;
        end else begin
            dreq_q <= bus.DBGRESETREQ;
            dbg_q  <= dbg_sync & ~bus.DBGRESETREQ & ~dreq_q;
        end
    end

    // PCLKEN divider; forced high around any PRESETn low period.
    always_ff @(posedge FCLK or posedge PORESET) begin
        if (PORESET) begin
            pclken_q <= 1'b1;
            div_q    <= '0;
        end else if (!prst_q || state_d != ST_RUN) begin
            pclken_q <= 1'b1;
            div_q    <= bus.PCLKDIV;
        end else if (div_q == '0) begin
            pclken_q <= 1'b1;
            div_q    <= bus.PCLKDIV;
        end else begin
            pclken_q <= 1'b0;
            div_q    <= div_q - 1'b1;
        end
    end

    assign bus.HRESETn   = bus.RSTBYPASS ? ~PORESET : hrst_q;
    assign bus.PRESETn   = bus.RSTBYPASS ? ~PORESET : prst_q;
    assign bus.DBGRESETn = bus.RSTBYPASS ? ~PORESET : dbg_q;
    assign bus.PCLKEN    = pclken_q;
    assign bus.RSTCAUSE  = cause_q;
    assign bus.RSTBUSY   = busy_q;
endmodule
